// File: rtl/alu_defs.sv
// Shared ALU definitions: op encodings and sequencer states.
// Used by the add32 sequencer and the ALU decoder.
package alu_defs;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ADC = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_SBC = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/prefix_adder.sv
// 16-bit Kogge-Stone prefix adder.
// Pure combinational; carry-in folded in after the prefix tree.
module prefix_adder (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] S,
  output logic        Cout
);

  logic [4:0][15:0] gl;
  logic [4:0][15:0] pl;
  logic [16:0]      c;

  // Prefix tree of group generate/propagate, then carries and sum
  always_comb begin
    gl = '0;
    pl = '0;
    c  = '0;
    gl[0] = A & B;
    pl[0] = A ^ B;
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < 16; i++) begin
        if (i >= (1 << l)) begin
          gl[l+1][i] = gl[l][i]
                     | (pl[l][i] & gl[l][i-(1<<l)]);
          pl[l+1][i] = pl[l][i] & pl[l][i-(1<<l)];
        end else begin
          gl[l+1][i] = gl[l][i];
          pl[l+1][i] = pl[l][i];
        end
      end
    end
    c[0] = Cin;
    for (int i = 0; i < 16; i++) begin
      c[i+1] = gl[4][i] | (pl[4][i] & Cin);
    end
  end

  assign S    = pl[0] ^ c[15:0];
  assign Cout = c[16];

endmodule

// File: rtl/add32_sequencer.sv
// Two-cycle 32-bit add/sub with NZCV, reusing one 16-bit adder.
// Low half in LO, high half with registered carry in HI.
module add32_sequencer
  import alu_defs::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic [1:0]  op_in,
  input  logic        c_flag_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [3:0]  nzcv
);

  seq_state_e  state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        cin_q, cin_d;
  logic        c16_q, c16_d;
  logic [15:0] lo_q, lo_d;
  logic [31:0] result_q, result_d;
  logic [3:0]  nzcv_q, nzcv_d;

  logic [31:0] b_eff;
  logic        cin_sel;
  logic [15:0] add_a, add_b, add_s;
  logic        add_cin, add_cout;
  logic [31:0] sum_full;
  logic        v_flag;

  // Op decode: effective B and carry-in
  always_comb begin
    b_eff   = b_in;
    cin_sel = 1'b0;
    unique case (op_in)
      OP_ADD: begin
        b_eff   = b_in;
        cin_sel = 1'b0;
      end
      OP_ADC: begin
        b_eff   = b_in;
        cin_sel = c_flag_in;
      end
      OP_SUB: begin
        b_eff   = ~b_in;
        cin_sel = 1'b1;
      end
      OP_SBC: begin
        b_eff   = ~b_in;
        cin_sel = c_flag_in;
      end
      default: begin
        b_eff   = b_in;
        cin_sel = 1'b0;
      end
    endcase
  end

  // Select adder half by state
  always_comb begin
    add_a   = a_q[15:0];
    add_b   = b_q[15:0];
    add_cin = cin_q;
    if (state_q == ST_HI) begin
      add_a   = a_q[31:16];
      add_b   = b_q[31:16];
      add_cin = c16_q;
    end
  end

  prefix_adder u_adder (
    .A    (add_a),
    .B    (add_b),
    .Cin  (add_cin),
    .S    (add_s),
    .Cout (add_cout)
  );

  assign sum_full = {add_s, lo_q};
  assign v_flag   = (a_q[31] == b_q[31])
                  && (add_s[15] != a_q[31]);

  // Next-state and datapath register updates
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    c16_d    = c16_q;
    lo_d     = lo_q;
    result_d = result_q;
    nzcv_d   = nzcv_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a_in;
          b_d     = b_eff;
          cin_d   = cin_sel;
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        lo_d    = add_s;
        c16_d   = add_cout;
        state_d = ST_HI;
      end
      ST_HI: begin
        result_d = sum_full;
        nzcv_d   = {add_s[15], sum_full == 32'd0,
                    add_cout, v_flag};
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      c16_q    <= 1'b0;
      lo_q     <= '0;
      result_q <= '0;
      nzcv_q   <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      c16_q    <= c16_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      nzcv_q   <= nzcv_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign nzcv      = nzcv_q;

endmodule
